// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: iterative unsigned divider sequencer.
// Runs a restoring division, one shift/trial-subtract/restore step per
// clock, over a single (WIDTH+1)-bit subtractor.
// A divide-by-zero request short-circuits straight to DONE.
//
// Ports:
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request pulse, sampled only in IDLE
//   dividend     unsigned dividend, captured on acceptance
//   divisor      unsigned divisor, captured on acceptance
//   busy         high in CALC and DONE
//   done         one-cycle pulse; results valid in that cycle
//   quotient     result quotient, held until the next accepted start
//   remainder    result remainder, held until the next accepted start
//   div_by_zero  set with done when the divisor was zero
module div_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   m_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   rem_q;
  logic               dbz_q;
  logic               busy_q;
  logic               done_q;

  // One restoring step, evaluated every cycle from registered state only.
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   a_d;
  logic [WIDTH-1:0]   q_d;
  logic               last_step;

  // The bit shifted out of Q enters A. The extra MSB on the subtractor
  // acts as the borrow flag: set means the trial went negative.
  assign a_sh      = {a_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign trial     = {1'b0, a_sh} - {1'b0, m_q};
  assign a_d       = trial[WIDTH] ? a_sh : trial[WIDTH-1:0];
  assign q_d       = {q_q[WIDTH-2:0], ~trial[WIDTH]};
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            if (divisor != '0) begin
              m_q     <= divisor;
              q_q     <= dividend;
              a_q     <= '0;
              cnt_q   <= '0;
              state_q <= S_CALC;
            end else begin
              // Zero divisor: no iterations, report all-ones quotient.
              quo_q   <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_CALC: begin
          a_q   <= a_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_step) begin
            quo_q   <= q_d;
            rem_q   <= a_d;
            dbz_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
module tb_div_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int errs;
  int checks;

  // Last result seen at a done pulse; outputs must hold these in between.
  logic [7:0] prev_q;
  logic [7:0] prev_r;
  logic       prev_z;

  div_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request from IDLE and follows it to its done pulse.
  // Cycle 1 is the cycle right after the accepting edge. If inj is
  // non-zero, a second start (50/5) is pulsed in cycle inj and the
  // operand inputs are left changed.
  task automatic run_div(input logic [7:0] dd, input logic [7:0] dv,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic ez, input int elat, input int inj,
                         input string nm);
    int cyc;
    bit seen;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL %s idle: busy=%b done=%b, required 0 0", nm, busy, done);
    end
    start = 1'b1; dividend = dd; divisor = dv;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    seen = 1'b0;
    while (cyc <= 20 && !seen) begin
      checks++;
      if (busy !== 1'b1) begin
        errs++;
        $display("FAIL %s busy cycle %0d: busy=%b, required 1", nm, cyc, busy);
      end
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        checks++;
        if (quotient !== prev_q || remainder !== prev_r || div_by_zero !== prev_z) begin
          errs++;
          $display("FAIL %s hold cycle %0d: q=%0d r=%0d z=%b, required %0d %0d %b",
                   nm, cyc, quotient, remainder, div_by_zero, prev_q, prev_r, prev_z);
        end
        if (inj != 0 && cyc == inj) begin
          start = 1'b1; dividend = 8'd50; divisor = 8'd5;
        end else if (inj != 0 && cyc == inj + 1) begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    checks++;
    if (!seen) begin
      errs++;
      $display("FAIL %s timeout: no done within 20 cycles, required cycle %0d", nm, elat);
    end else begin
      checks++;
      if (cyc != elat) begin
        errs++;
        $display("FAIL %s latency: done in cycle %0d, required %0d", nm, cyc, elat);
      end
      checks++;
      if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
        errs++;
        $display("FAIL %s result: q=%0d r=%0d z=%b, required %0d %0d %b",
                 nm, quotient, remainder, div_by_zero, eq, er, ez);
      end
      if (dv != 8'd0) begin
        checks++;
        if (int'(quotient) * int'(dv) + int'(remainder) != int'(dd) || remainder >= dv) begin
          errs++;
          $display("FAIL %s invariant: q=%0d r=%0d for %0d/%0d", nm, quotient, remainder, dd, dv);
        end
      end
    end
    prev_q = quotient;
    prev_r = remainder;
    prev_z = div_by_zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL reset ctrl: busy=%b done=%b, required 0 0", busy, done);
    end
    checks++;
    if (quotient !== 8'd0 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      errs++;
      $display("FAIL reset data: q=%0d r=%0d z=%b, required 0 0 0", quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
    prev_q = 8'd0; prev_r = 8'd0; prev_z = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL post-reset idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    run_div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9, 0, "100/7");
  endtask

  task automatic test_boundary();
    run_div(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 9, 0, "255/1");
    run_div(8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 9, 0, "255/255");
    run_div(8'd5,   8'd200, 8'd0,   8'd5,  1'b0, 9, 0, "5/200");
    run_div(8'd200, 8'd128, 8'd1,   8'd72, 1'b0, 9, 0, "200/128");
    run_div(8'd0,   8'd9,   8'd0,   8'd0,  1'b0, 9, 0, "0/9");
  endtask

  task automatic test_div_zero();
    run_div(8'd42, 8'd0, 8'hFF, 8'd42, 1'b1, 1, 0, "42/0");
    run_div(8'd9,  8'd3, 8'd3,  8'd0,  1'b0, 9, 0, "9/3");
  endtask

  task automatic test_back_to_back();
    run_div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9, 4, "100/7 ignore");
    run_div(8'd50,  8'd5, 8'd10, 8'd0, 1'b0, 9, 0, "50/5 b2b");
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    start = 1'b1; dividend = 8'd255; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    // now in cycle 4; the next negedge is cycle 5
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd0 ||
        remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      errs++;
      $display("FAIL abort outputs: busy=%b done=%b q=%0d r=%0d z=%b, required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errs++;
        $display("FAIL abort held %0d: busy=%b done=%b, required 0 0", i, busy, done);
      end
    end
    rst_n = 1'b1;
    prev_q = 8'd0; prev_r = 8'd0; prev_z = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL abort release: busy=%b done=%b, required 0 0", busy, done);
    end
    run_div(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 9, 0, "9/2 after abort");
  endtask

  task automatic test_random();
    logic [7:0] dd, dv, eq, er;
    logic ez;
    int lat;
    for (int n = 0; n < 3000; n++) begin
      dd = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) dv = 8'd0;
      else dv = 8'($urandom_range(0, 255));
      if (dv == 8'd0) begin
        eq = 8'hFF; er = dd; ez = 1'b1; lat = 1;
      end else begin
        eq = dd / dv; er = dd % dv; ez = 1'b0; lat = 9;
      end
      run_div(dd, dv, eq, er, ez, lat, 0, "random");
    end
    // the pulse that ended the last request must drop after one cycle
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL final pulse width: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_boundary();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
